alu: RTL and testbench
======================

Name: alu

Overview:
- RV32IM integer ALU for the execute stage of the pipelined CPU.
- Single-cycle combinational result for RV32I OP/OP-IMM and for the M-extension multiplies.
- Iterative multi-cycle divide/remainder, sequenced by a ready/done handshake.
- The EX stage holds all inputs stable until done is high.

Parameters:
- DIV_CYCLES, 32: iteration count of the restoring divider; equals the operand width and is fixed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in1  in  32  operand 1 (rs1).
- in2  in  32  operand 2 (rs2, or the sign-extended I-immediate when is_imm=1).
- is_imm  in  1  1 = OP-IMM instruction, 0 = OP instruction.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7 (instr[31:25]).
- ready  in  1  one-cycle start pulse, asserted in the first cycle an ALU instruction is in EX.
- out  out  32  result.
- done  out  1  result valid / ALU idle.

Behaviour:
- Reset (rst=0, asynchronous):
  - busy cleared, divider state and result register = 0, done=1.
  - Reset during a divide aborts it.
- Base ops (combinational out, done=1), selected by funct3 (in2 is the operand in all cases):
  - 000 ADD; SUB when is_imm=0 and funct7[5]=1. With is_imm=1 it is always ADD, funct7 ignored.
  - 001 SLL by in2[4:0].
  - 010 SLT, signed compare, result 1 or 0.
  - 011 SLTU, unsigned compare.
  - 100 XOR.
  - 101 SRL, or SRA when funct7[5]=1 (applies to both OP and OP-IMM), shift amount in2[4:0].
  - 110 OR.
  - 111 AND.
- M-extension is selected when is_imm=0 and funct7=0000001. funct7 values other than 0000000, 0100000 and 0000001 decode as base ops using funct7[5] only.
- Multiplies (combinational, done=1):
  - 000 MUL: low 32 bits.
  - 001 MULH: signed×signed, high 32 bits.
  - 010 MULHSU: signed in1 × unsigned in2, high 32 bits.
  - 011 MULHU: unsigned×unsigned, high 32 bits.
- Divides: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - ready=1 with a divide op in cycle N: busy set; done=0 combinationally in cycle N and through N+32; done=1 from N+33.
  - Latency is 33 cycles total.
  - While busy, out is don't-care. After completion, out = result register, held until the next ready.
  - Signed ops divide magnitudes. Quotient is negated if the operand signs differ; remainder takes the sign of in1.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = in1. No extra cycles are required, but the 33-cycle latency must be kept uniformly.
  - Overflow (in1=0x80000000, in2=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- ready while busy: ignored.
- ready with a non-divide op: no state change; done stays 1.
- done is low only during a divide sequence (including its start cycle).
- All arithmetic is modulo 2^32; no flags.

Decomposition:
- Shared package alu_pkg:
  - funct3 encoding constants (F3_ADD..F3_AND, F3_MUL..F3_REMU).
  - FUNCT7_MULDIV = 7'b0000001.
  - FUNCT7_ALT bit index 5.
- Sub-module alu_divider: the iterative unsigned restoring divider (start, dividend, divisor → quotient, remainder, busy). Sign handling, divide-by-zero/overflow and result selection live in alu.

Test Plan:
- Base ops, ready pulsed:
  - in1=5, in2=0xFFFFFFFD, is_imm=0, funct7=0x20, f3=000 → out=8, done=1 the same cycle.
  - is_imm=1, funct7=0x20, f3=000 → out=2 (ADD).
- Shifts and compares:
  - in1=0x80000000, in2=4: f3=101, funct7=0x20, is_imm=1 → 0xF8000000; funct7=0 → 0x08000000.
  - in1=-1, in2=1: f3=010 → 1; f3=011 → 0.
- Multiplies with in1=0xFFFFFFFF, in2=0xFFFFFFFF, funct7=1:
  - MUL → 0x00000001; MULH → 0; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF. done=1 each.
- Divide in1=-7, in2=2, pulse ready at cycle N:
  - DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - done=0 during N..N+32, 1 at N+33; out held after completion.
- Corner cases:
  - DIVU x/0 → 0xFFFFFFFF.
  - REM 9/0 → 9.
  - DIV 0x80000000/-1 → 0x80000000; REM → 0.
- Reset and handshake:
  - assert rst=0 at cycle N+10 of a divide → done=1 immediately and asynchronously; a new divide afterwards completes correctly.
  - ready pulses while busy are ignored.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32IM execute-stage ALU and its divider.
//   - funct3 encodings for the base integer ops and the M-extension ops
//   - funct7 decode values (MUL/DIV selector and the alternate-op bit index)
//   - divider sizing and FSM state type
//   - small helpers for sign-magnitude conversion used around the divider
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN       = 32;
  // The restoring divider retires one quotient bit per cycle, so the
  // iteration count is tied to the operand width and is not tunable.
  localparam int DIV_CYCLES = XLEN;
  localparam int DIV_CNT_W  = $clog2(DIV_CYCLES);

  // Base integer ops (OP / OP-IMM)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // M-extension ops (OP with funct7 = FUNCT7_MULDIV)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  // funct7 bit that turns ADD into SUB and SRL into SRA
  localparam int         FUNCT7_ALT    = 5;

  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic {
    DIV_IDLE,
    DIV_BUSY
  } divState_t;

  // Magnitude of a value that is treated as two's complement only when
  // signedOp is set; unsigned divides pass the operand straight through.
  function automatic logic [XLEN-1:0] absVal(input logic [XLEN-1:0] value,
                                             input logic            signedOp);
    return (signedOp && value[XLEN-1]) ? -value : value;
  endfunction

  function automatic logic [XLEN-1:0] negateIf(input logic [XLEN-1:0] value,
                                               input logic            doNegate);
    return doNegate ? -value : value;
  endfunction

endpackage

// File: rtl/alu_divider.sv
// -----------------------------------------------------------------------------
// alu_divider
// Iterative unsigned restoring divider, one quotient bit per clock.
// A start pulse while idle loads the operands; the next DIV_CYCLES rising
// edges each perform one shift/trial-subtract step. During the final step
// o_finish is high and o_quotient/o_remainder already carry the completed
// result, so the parent can capture it on that same edge.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset (aborts a running divide)
//   i_start      begin a divide (ignored while busy)
//   i_dividend   unsigned dividend, sampled on start
//   i_divisor    unsigned divisor, sampled on start
//   o_quotient   quotient after the step being performed this cycle
//   o_remainder  remainder after the step being performed this cycle
//   o_busy       a divide is in progress
//   o_finish     this cycle performs the last step
// Divide by zero needs no special case here: every trial subtract succeeds,
// giving an all-ones quotient and the dividend as remainder.
// -----------------------------------------------------------------------------
module alu_divider
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder,
  output logic            o_busy,
  output logic            o_finish
);

  divState_t              r_state;
  logic [XLEN-1:0]        r_quo;
  logic [XLEN-1:0]        r_rem;
  logic [XLEN-1:0]        r_divisor;
  logic [DIV_CNT_W-1:0]   r_count;

  logic [XLEN:0]          w_shifted;
  logic [XLEN:0]          w_diff;
  logic [XLEN-1:0]        w_quoNext;
  logic [XLEN-1:0]        w_remNext;

  // One restoring step: bring the next dividend bit (held in the top of the
  // quotient register) into the partial remainder and try to subtract the
  // divisor. A clear borrow bit means the subtraction fits, so keep the
  // difference and shift a 1 into the quotient; otherwise restore.
  always_comb begin
    w_shifted = {r_rem, r_quo[XLEN-1]};
    w_diff    = w_shifted - {1'b0, r_divisor};
    if (!w_diff[XLEN]) begin
      w_remNext = w_diff[XLEN-1:0];
      w_quoNext = {r_quo[XLEN-2:0], 1'b1};
    end else begin
      w_remNext = w_shifted[XLEN-1:0];
      w_quoNext = {r_quo[XLEN-2:0], 1'b0};
    end
  end

  // Divider sequencer: idle until started, then run exactly DIV_CYCLES
  // steps regardless of operand values so the latency is always the same.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DIV_IDLE;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (i_start) begin
            r_quo     <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
            r_count   <= '0;
            r_state   <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          r_quo   <= w_quoNext;
          r_rem   <= w_remNext;
          r_count <= r_count + 1'b1;
          if (r_count == DIV_CNT_W'(DIV_CYCLES - 1)) begin
            r_state <= DIV_IDLE;
          end
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state == DIV_BUSY);
  assign o_finish    = o_busy && (r_count == DIV_CNT_W'(DIV_CYCLES - 1));
  assign o_quotient  = w_quoNext;
  assign o_remainder = w_remNext;

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// RV32IM execute-stage integer ALU.
// Base OP/OP-IMM ops and the four multiplies produce a combinational result
// with done held high. DIV/DIVU/REM/REMU run on the iterative divider:
// done drops in the cycle ready is seen and returns high 33 cycles later,
// after which out shows the registered result until the next ready.
//
// Ports
//   clk     clock, rising edge
//   rst     asynchronous active-low reset (aborts a running divide)
//   in1     operand 1 (rs1)
//   in2     operand 2 (rs2 or sign-extended immediate)
//   is_imm  1 = OP-IMM, 0 = OP
//   funct3  instruction funct3
//   funct7  instruction funct7
//   ready   one-cycle start pulse for the instruction now in EX
//   out     result
//   done    result valid / ALU idle
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            is_imm,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            ready,
  output logic [XLEN-1:0] out,
  output logic            done
);

  logic                   w_isMulDiv;
  logic                   w_isDiv;
  logic                   w_alt;
  logic                   w_start;
  logic                   w_signedDiv;
  logic [4:0]             w_shamt;

  logic signed [XLEN:0]   w_mulA;
  logic signed [XLEN:0]   w_mulB;
  logic signed [63:0]     w_product;

  logic [XLEN-1:0]        w_combResult;

  logic [XLEN-1:0]        w_divQuotient;
  logic [XLEN-1:0]        w_divRemainder;
  logic                   w_divBusy;
  logic                   w_divFinish;
  logic [XLEN-1:0]        w_quoFinal;
  logic [XLEN-1:0]        w_remFinal;

  logic [XLEN-1:0]        r_result;
  logic                   r_showResult;
  logic                   r_isRem;
  logic                   r_negQuo;
  logic                   r_negRem;
  logic                   r_divZero;
  logic                   r_overflow;

  // Decode. Only the exact MULDIV funct7 on an OP instruction selects the
  // M-extension; every other funct7 falls back to the base ops and only
  // its alternate bit matters there.
  assign w_isMulDiv  = !is_imm && (funct7 == FUNCT7_MULDIV);
  assign w_isDiv     = w_isMulDiv && funct3[2];
  assign w_alt       = funct7[FUNCT7_ALT];
  assign w_shamt     = in2[4:0];
  assign w_start     = ready && w_isDiv && !w_divBusy;
  assign w_signedDiv = !funct3[0];

  // One 33x33 signed multiplier covers all four multiplies: each operand is
  // extended with its sign bit when that side is signed, with zero otherwise.
  assign w_mulA    = {((funct3 == F3_MULH) || (funct3 == F3_MULHSU)) ? in1[XLEN-1] : 1'b0, in1};
  assign w_mulB    = {(funct3 == F3_MULH) ? in2[XLEN-1] : 1'b0, in2};
  assign w_product = 64'(w_mulA) * 64'(w_mulB);

  // Single-cycle result for base ops and multiplies. Divides have no
  // combinational value; their result comes from r_result.
  always_comb begin
    w_combResult = '0;
    if (w_isMulDiv) begin
      case (funct3)
        F3_MUL:    w_combResult = w_product[XLEN-1:0];
        F3_MULH,
        F3_MULHSU,
        F3_MULHU:  w_combResult = w_product[2*XLEN-1:XLEN];
        default:   w_combResult = '0;
      endcase
    end else begin
      case (funct3)
        F3_ADD:  w_combResult = (!is_imm && w_alt) ? (in1 - in2) : (in1 + in2);
        F3_SLL:  w_combResult = in1 << w_shamt;
        F3_SLT:  w_combResult = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
        F3_SLTU: w_combResult = {{(XLEN-1){1'b0}}, in1 < in2};
        F3_XOR:  w_combResult = in1 ^ in2;
        F3_SR:   w_combResult = w_alt ? XLEN'($signed(in1) >>> w_shamt) : (in1 >> w_shamt);
        F3_OR:   w_combResult = in1 | in2;
        F3_AND:  w_combResult = in1 & in2;
        default: w_combResult = '0;
      endcase
    end
  end

  // The divider only ever sees magnitudes; signs are reapplied afterwards.
  alu_divider u_divider (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_dividend  (absVal(in1, w_signedDiv)),
    .i_divisor   (absVal(in2, w_signedDiv)),
    .o_quotient  (w_divQuotient),
    .o_remainder (w_divRemainder),
    .o_busy      (w_divBusy),
    .o_finish    (w_divFinish)
  );

  // Turn the unsigned divider result into the architectural one. Quotient is
  // negative when operand signs differ; remainder follows the dividend.
  // Divide by zero forces an all-ones quotient (the remainder magnitude is
  // already |in1|, so re-signing it yields in1). The INT_MIN / -1 overflow
  // case is pinned explicitly rather than relying on wraparound.
  always_comb begin
    w_quoFinal = negateIf(w_divQuotient, r_negQuo);
    w_remFinal = negateIf(w_divRemainder, r_negRem);
    if (r_divZero) begin
      w_quoFinal = '1;
    end
    if (r_overflow) begin
      w_quoFinal = INT_MIN;
      w_remFinal = '0;
    end
  end

  // Divide bookkeeping: capture the sign/special-case flags while the EX
  // stage still presents the operands, latch the final result on the last
  // divider step, and stop showing it once the next instruction arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result     <= '0;
      r_showResult <= 1'b0;
      r_isRem      <= 1'b0;
      r_negQuo     <= 1'b0;
      r_negRem     <= 1'b0;
      r_divZero    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_start) begin
        r_isRem      <= funct3[1];
        r_negQuo     <= w_signedDiv && (in1[XLEN-1] ^ in2[XLEN-1]);
        r_negRem     <= w_signedDiv && in1[XLEN-1];
        r_divZero    <= (in2 == '0);
        r_overflow   <= w_signedDiv && (in1 == INT_MIN) && (in2 == '1);
        r_showResult <= 1'b0;
      end else if (ready && !w_divBusy) begin
        r_showResult <= 1'b0;
      end
      if (w_divFinish) begin
        r_result     <= r_isRem ? w_remFinal : w_quoFinal;
        r_showResult <= 1'b1;
      end
    end
  end

  // A completed divide result is held on out until the next ready pulse;
  // otherwise out follows the combinational path.
  assign out  = (r_showResult && !ready) ? r_result : w_combResult;
  assign done = !(w_divBusy || (ready && w_isDiv));

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
// Self-checking bench for the RV32IM ALU. Each instruction pushes its
// expected result into a scoreboard queue; the entry is popped and compared
// when the ALU reports done. Inputs change on the falling edge and outputs
// are sampled shortly after it, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        is_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        ready;
  logic [31:0] out;
  logic        done;

  logic [31:0] expQ[$];
  int          checkCount;
  int          errorCount;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .in1    (in1),
    .in2    (in2),
    .is_imm (is_imm),
    .funct3 (funct3),
    .funct7 (funct7),
    .ready  (ready),
    .out    (out),
    .done   (done)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Independent reference for random stimulus, built on 64-bit integer
  // arithmetic and the language's own division semantics.
  function automatic logic [31:0] refModel(input logic imm, input logic [6:0] f7,
                                           input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    if (!imm && f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = sa * sb; return p[31:0]; end
        3'd1: begin p = sa * sb; return p[63:32]; end
        3'd2: begin p = sa * ub; return p[63:32]; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
        3'd4: begin
          if (b == 0) return 32'hFFFF_FFFF;
          p = sa / sb;
          return p[31:0];
        end
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: begin
          if (b == 0) return a;
          p = sa % sb;
          return p[31:0];
        end
        default: return (b == 0) ? a : a % b;
      endcase
    end
    case (f3)
      3'd0: return (!imm && f7[5]) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        p = f7[5] ? 64'(sa >>> b[4:0]) : {32'b0, a >> b[4:0]};
        return p[31:0];
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Drive one instruction with a ready pulse. Non-divides are checked in the
  // same cycle. Divides are followed until done returns (bounded), the
  // latency is checked, and the result is checked both on completion and one
  // cycle later with the operands changed and no ready. A non-zero pokeAt
  // re-pulses ready that many cycles into the divide.
  task automatic applyStimulus(input string tag, input logic imm, input logic [6:0] f7,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected,
                               input int pokeAt);
    logic [31:0] want;
    int          lat;
    @(negedge clk);
    in1    = a;
    in2    = b;
    is_imm = imm;
    funct7 = f7;
    funct3 = f3;
    ready  = 1'b1;
    expQ.push_back(expected);
    #1;
    if (!imm && f7 == 7'h01 && f3[2]) begin
      checkOutput({tag, " done low at start"}, {31'b0, done}, 32'd0);
      lat = 0;
      while (lat < 40) begin
        @(negedge clk);
        lat++;
        ready = (lat == pokeAt);
        #1;
        if (done) break;
      end
      ready = 1'b0;
      checkOutput({tag, " latency"}, lat, 32'd33);
      want = expQ.pop_front();
      checkOutput(tag, out, want);
      @(negedge clk);
      in1    = ~a;
      in2    = 32'd3;
      funct7 = 7'h00;
      funct3 = 3'd0;
      #1;
      checkOutput({tag, " held"}, out, want);
    end else begin
      checkOutput({tag, " done"}, {31'b0, done}, 32'd1);
      want = expQ.pop_front();
      checkOutput(tag, out, want);
      @(negedge clk);
      ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] dropped;
    logic [6:0]  rf7;
    logic [2:0]  rf3;
    logic        rimm;

    checkCount = 0;
    errorCount = 0;
    rst    = 1'b0;
    in1    = '0;
    in2    = '0;
    is_imm = 1'b0;
    funct3 = '0;
    funct7 = '0;
    ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset done", {31'b0, done}, 32'd1);
    checkOutput("reset out", out, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Base ops
    applyStimulus("SUB",        1'b0, 7'h20, 3'd0, 32'd5, 32'hFFFF_FFFD, 32'd8, 0);
    applyStimulus("ADDI alt",   1'b1, 7'h20, 3'd0, 32'd5, 32'hFFFF_FFFD, 32'd2, 0);
    applyStimulus("SRAI",       1'b1, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 32'hF800_0000, 0);
    applyStimulus("SRLI",       1'b1, 7'h00, 3'd5, 32'h8000_0000, 32'd4, 32'h0800_0000, 0);
    applyStimulus("SLT",        1'b0, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    applyStimulus("SLTU",       1'b0, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    applyStimulus("SLL",        1'b0, 7'h00, 3'd1, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 0);
    applyStimulus("XOR",        1'b0, 7'h00, 3'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 0);
    applyStimulus("OR",         1'b0, 7'h00, 3'd6, 32'hF000_0001, 32'h0000_0100, 32'hF000_0101, 0);
    applyStimulus("AND",        1'b0, 7'h00, 3'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0);
    applyStimulus("odd f7 SUB", 1'b0, 7'h60, 3'd0, 32'd10, 32'd3, 32'd7, 0);
    applyStimulus("odd f7 ADD", 1'b0, 7'h41, 3'd0, 32'd10, 32'd3, 32'd13, 0);
    applyStimulus("odd f7 SRA", 1'b0, 7'h21, 3'd5, 32'h8000_0000, 32'd1, 32'hC000_0000, 0);

    // Multiplies
    applyStimulus("MUL",    1'b0, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    applyStimulus("MULH",   1'b0, 7'h01, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    applyStimulus("MULHU",  1'b0, 7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    applyStimulus("MULHSU", 1'b0, 7'h01, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Divides, including a ready pulse while busy that must be ignored
    applyStimulus("DIV -7/2",    1'b0, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5);
    applyStimulus("REM -7/2",    1'b0, 7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    applyStimulus("DIVU 100/7",  1'b0, 7'h01, 3'd5, 32'd100, 32'd7, 32'd14, 20);
    applyStimulus("REMU 100/7",  1'b0, 7'h01, 3'd7, 32'd100, 32'd7, 32'd2, 0);
    applyStimulus("DIVU x/0",    1'b0, 7'h01, 3'd5, 32'd12345, 32'd0, 32'hFFFF_FFFF, 0);
    applyStimulus("DIV -7/0",    1'b0, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0);
    applyStimulus("REM 9/0",     1'b0, 7'h01, 3'd6, 32'd9, 32'd0, 32'd9, 0);
    applyStimulus("REM -9/0",    1'b0, 7'h01, 3'd6, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 0);
    applyStimulus("DIV ovf",     1'b0, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    applyStimulus("REM ovf",     1'b0, 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Reset in the middle of a divide, then a clean divide afterwards
    @(negedge clk);
    in1    = 32'd100;
    in2    = 32'd7;
    is_imm = 1'b0;
    funct7 = 7'h01;
    funct3 = 3'd4;
    ready  = 1'b1;
    expQ.push_back(32'd14);
    @(negedge clk);
    ready = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    checkOutput("busy before abort", {31'b0, done}, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset abort done", {31'b0, done}, 32'd1);
    dropped = expQ.pop_front();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus("DIV after reset", 1'b0, 7'h01, 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0);
    applyStimulus("REM after reset", 1'b0, 7'h01, 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);

    // Random instructions against the reference model
    for (int i = 0; i < 24; i++) begin
      rimm = 1'($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       rf7 = 7'h00;
        1:       rf7 = 7'h20;
        2:       rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      rf3 = 3'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      applyStimulus($sformatf("rand%0d f7=%02h f3=%0d imm=%0d", i, rf7, rf3, rimm),
                    rimm, rf7, rf3, ra, rb, refModel(rimm, rf7, rf3, ra, rb), 0);
    end

    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
